// File: rtl/video_sprite_loader_if.sv
// rtl/video_sprite_loader_if.sv - command, byte stream and sprite RAM write bundle for the sprite loader
interface video_sprite_loader_if #(
   parameter int RGB_SIZE      = 12,
   parameter int SPRITE_IDXW   = 2,
   parameter int SPRITE_RAM_AW = 12
);
   logic                     cmd_start;
   logic                     cmd_all;
   logic [SPRITE_IDXW-1:0]   cmd_idx;
   logic                     cmd_abort;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic [7:0]               s_data;
   logic                     s_valid;
   logic                     s_ready;
   logic                     sprite_ram_we;
   logic [SPRITE_RAM_AW-1:0] sprite_ram_addr_w;
   logic [RGB_SIZE-1:0]      sprite_ram_din;

   modport master (
      output cmd_start, cmd_all, cmd_idx, cmd_abort, s_data, s_valid,
      input  busy, done, err, s_ready, sprite_ram_we, sprite_ram_addr_w, sprite_ram_din
   );

   modport slave (
      input  cmd_start, cmd_all, cmd_idx, cmd_abort, s_data, s_valid,
      output busy, done, err, s_ready, sprite_ram_we, sprite_ram_addr_w, sprite_ram_din
   );
endinterface

// File: rtl/video_sprite_loader.sv
// rtl/video_sprite_loader.sv - packs a byte stream into RGB pixels and writes one or all sprite frames
module video_sprite_loader #(
   parameter int RGB_SIZE      = 12,
   parameter int SPRITE_AW     = 10,
   parameter int SPRITE_IDXW   = 2,
   parameter int SPRITE_RAM_AW = SPRITE_AW + SPRITE_IDXW,
   parameter int SPRITE_NUM    = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   video_sprite_loader_if.slave bus
);
   localparam int BPP  = (RGB_SIZE + 7) / 8;
   localparam int PIXW = BPP * 8;
   localparam int PW   = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int CW   = SPRITE_RAM_AW + 1;
   localparam int IW1  = SPRITE_IDXW + 1;
   localparam logic [CW-1:0]  FRAME_PIX = CW'(2 ** SPRITE_AW);
   localparam logic [CW-1:0]  ALL_PIX   = CW'(SPRITE_NUM * (2 ** SPRITE_AW));
   localparam logic [PW-1:0]  LAST_PH   = PW'(BPP - 1);
   localparam logic [IW1-1:0] NUM_W     = IW1'(SPRITE_NUM);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [SPRITE_RAM_AW-1:0] base_q, base_d;
   logic [CW-1:0]            target_q, target_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [PW-1:0]            phase_q, phase_d;
   logic [PIXW-1:0]          pix_q, pix_d;
   logic                     we_q, we_d;
   logic [SPRITE_RAM_AW-1:0] addr_q, addr_d;
   logic [RGB_SIZE-1:0]      din_q, din_d;
   logic                     err_q, err_d;
   logic [PIXW-1:0]          full_pix;

   logic cmd_bad, acc, pix_last, frame_last;

   assign cmd_bad    = !bus.cmd_all && ({1'b0, bus.cmd_idx} >= NUM_W);
   assign acc        = (state_q == S_LOAD) && bus.s_valid;
   assign pix_last   = acc && (phase_q == LAST_PH);
   assign frame_last = pix_last && ((cnt_q + CW'(1)) == target_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort outranks completion, including a last byte accepted in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_start && !cmd_bad) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (bus.cmd_abort)   state_d = S_IDLE;
            else if (frame_last) state_d = S_FLUSH;
         end
         S_FLUSH: state_d = bus.cmd_abort ? S_IDLE : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy    = (state_q == S_LOAD) || (state_q == S_FLUSH);
      bus.done    = (state_q == S_DONE);
      bus.s_ready = (state_q == S_LOAD);
   end

   assign bus.err               = err_q;
   assign bus.sprite_ram_we     = we_q;
   assign bus.sprite_ram_addr_w = addr_q;
   assign bus.sprite_ram_din    = din_q;

   always_comb begin
      base_d   = base_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      pix_d    = pix_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      err_d    = 1'b0;
      full_pix = pix_q;
      full_pix[(BPP-1)*8 +: 8] = bus.s_data;

      if ((state_q == S_IDLE) && bus.cmd_start) begin
         if (cmd_bad) begin
            err_d = 1'b1;
         end else begin
            base_d   = bus.cmd_all ? '0 : (SPRITE_RAM_AW'(bus.cmd_idx) << SPRITE_AW);
            target_d = bus.cmd_all ? ALL_PIX : FRAME_PIX;
            cnt_d    = '0;
            phase_d  = '0;
            pix_d    = '0;
         end
      end

      // Bytes arrive little-endian; the last one completes the pixel and issues the write.
      if (acc) begin
         if (pix_last) begin
            we_d    = 1'b1;
            addr_d  = base_q + cnt_q[SPRITE_RAM_AW-1:0];
            din_d   = full_pix[RGB_SIZE-1:0];
            cnt_d   = cnt_q + CW'(1);
            phase_d = '0;
         end else begin
            pix_d[int'(phase_q)*8 +: 8] = bus.s_data;
            phase_d = phase_q + PW'(1);
         end
      end
   end

   generate
      if (PIXW > RGB_SIZE) begin : g_discard
         logic unused_hi;
         assign unused_hi = ^full_pix[PIXW-1:RGB_SIZE];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         phase_q  <= '0;
         pix_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         base_q   <= base_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         pix_q    <= pix_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         err_q    <= err_d;
      end
   end
endmodule
